// File: rtl/keypad_pkg.sv
// Shared types, key map and sizing helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_e;

    // Indexed by {row[1:0], col[1:0]}; entry 0 is row0/col0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Bits needed for a counter running 0 .. max_val-1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad rows; idles (and resets) to all ones.
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] async_i,
    output logic [3:0] sync_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner/debouncer: each accepted key shifts into num and pulses key_valid.
// Defining KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key stays held.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 50000,
    parameter int REPEAT_CYC = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] num,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int SW = cnt_w(SCAN_DIV);
    localparam int DW = cnt_w(DEBOUNCE);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

    if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_CYC < 1) begin : g_bad_cfg
        $error("keypad_entry: SCAN_DIV must be >= 4, DEBOUNCE and REPEAT_CYC >= 1");
    end

    logic [3:0]    row_s;
    state_e        state_q, state_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    code_q, code_d;
    logic [15:0]   num_q, num_d;
    logic          vld_q, vld_d;
    logic          row_bit;
    logic          accept;
    logic [3:0]    key_now;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = cnt_w(REPEAT_CYC);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rpt_q, rpt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`endif

    keypad_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (row),
        .sync_o  (row_s)
    );

    assign row_bit = row_s[ridx_q];
    assign key_now = KEY_MAP[{ridx_q, cidx_q}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SCAN;
            scan_q  <= '0;
            deb_q   <= '0;
            cidx_q  <= 2'd0;
            ridx_q  <= 2'd0;
            col_q   <= 4'b1110;
            code_q  <= 4'h0;
            num_q   <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            deb_q   <= deb_d;
            cidx_q  <= cidx_d;
            ridx_q  <= ridx_d;
            col_q   <= col_d;
            code_q  <= code_d;
            num_q   <= num_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        deb_d   = deb_q;
        cidx_d  = cidx_q;
        ridx_d  = ridx_q;
        accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    if (~&row_s) begin
                        ridx_d  = low_row(row_s);
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        cidx_d = cidx_q + 2'd1;
                    end
                end else begin
                    scan_d = scan_q + SW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (row_bit) begin
                    deb_d   = '0;
                    cidx_d  = cidx_q + 2'd1;
                    state_d = ST_SCAN;
                end else if (deb_q == DEB_LAST) begin
                    deb_d   = '0;
                    accept  = 1'b1;
                    state_d = ST_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            ST_HELD: begin
                if (row_bit) begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    rpt_d = '0;
`endif
                    if (deb_q == DEB_LAST) begin
                        deb_d   = '0;
                        cidx_d  = cidx_q + 2'd1;
                        state_d = ST_SCAN;
                    end else begin
                        deb_d = deb_q + DW'(1);
                    end
                end else begin
                    // Release count must be consecutive; any low sample restarts it.
                    deb_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rpt_q == RPT_LAST) begin
                        rpt_d  = '0;
                        accept = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RW'(1);
                    end
`endif
                end
            end
            default: state_d = ST_SCAN;
        endcase

        vld_d  = accept;
        code_d = accept ? key_now : code_q;
        num_d  = accept ? {num_q[11:0], key_now} : num_q;
        col_d  = ~(4'b0001 << cidx_d);
    end

    assign col       = col_q;
    assign num       = num_q;
    assign key_code  = code_q;
    assign key_valid = vld_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: physical keypad model driving rows from col, randomized presses vs a timing/value model.
module tb_keypad_entry;

    localparam int SP = 4;
    localparam int DB = 8;
    localparam int RC = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] num;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] pk;
    logic        ovr_en;
    logic [3:0]  ovr;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int model_num = 0;
    int row_codes [4] = '{'h123A, 'h456B, 'h789C, 'h0FED};

    int          pv_cyc  [$];
    logic [3:0]  pv_code [$];
    logic [15:0] pv_num  [$];

    keypad_entry #(
        .SCAN_DIV   (SP),
        .DEBOUNCE   (DB),
        .REPEAT_CYC (RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .num       (num),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pk[r*4+c] && !col[c]) row[r] = 1'b0;
        if (ovr_en) row = ovr;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pv_cyc.push_back(cyc);
            pv_code.push_back(key_code);
            pv_num.push_back(num);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] colv(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c[1:0]] = 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] code_of(input int r, input int c);
        return 4'((row_codes[r] >> (4 * (3 - c))) & 15);
    endfunction

    task automatic model_shift(input logic [3:0] code);
        model_num = (model_num * 16 + int'(code)) % 65536;
    endtask

    // Press mask (all keys in column c), expect acceptance; hold<0 leaves the key down.
    task automatic press(input logic [15:0] mask, input int c, input int hold, input logic [3:0] code);
        int s, v, r, guard, nexp;
        guard = 0;
        pv_cyc.delete(); pv_code.delete(); pv_num.delete();
        while (col == colv(c) && guard < 40) begin
            tick();
            guard++;
        end
        pk = mask;
        s = -1;
        for (int i = 0; i < 40 && s < 0; i++) begin
            tick();
            if (col == colv(c)) s = cyc;
        end
        chk("reach_col", 32'(s >= 0), 32'd1);
        if (s < 0) begin
            pk = '0;
            return;
        end
        for (int i = 0; i < 60 && pv_cyc.size() == 0; i++) tick();
        if (pv_cyc.size() == 0) begin
            chk("vld_timeout", 32'd0, 32'd1);
            pk = '0;
            return;
        end
        v = pv_cyc[0];
        chk("vld_latency", v - s, SP + DB);
        chk("key_code", pv_code[0], code);
        model_shift(code);
        chk("num", pv_num[0], model_num);
        if (hold < 0) return;
        while (cyc < v + hold) tick();
        pk = '0;
        r = cyc;
        while (cyc < r + 9) tick();
        chk("held_col", col, colv(c));
        tick();
        chk("resume_col", col, colv((c + 1) % 4));
`ifdef KEYPAD_AUTOREPEAT_EN
        nexp = 1 + (r + 2 - v) / RC;
`else
        nexp = 1;
`endif
        chk("pulses", pv_cyc.size(), nexp);
        for (int i = 1; i < nexp; i++) model_shift(code);
        chk("num_after", num, model_num);
    endtask

    initial begin
        int s, kr, kc, prev;
        pk = '0;
        ovr_en = 1'b0;
        ovr = 4'hF;
        rst = 1'b1;

        // Reset state and scan order
        repeat (3) tick();
        chk("rst_col", col, 4'b1110);
        chk("rst_num", num, 16'h0000);
        chk("rst_vld", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("scan_col", col, colv((i / 4) % 4));
            tick();
        end

        // Single press of key 5
        press(16'h1 << (1*4+1), 1, 30, 4'h5);
        chk("num_key5", num, 16'h0005);

        // Sequence 1 2 3 A then 4
        for (int c = 0; c < 4; c++) press(16'h1 << c, c, 20, code_of(0, c));
        chk("num_123A", num, 16'h123A);
        press(16'h1 << 4, 0, 20, code_of(1, 0));
        chk("num_23A4", num, 16'h23A4);

        // Bounce: row0 low for 3 cycles at the start of column 0's slot
        pv_cyc.delete(); pv_code.delete(); pv_num.delete();
        prev = col;
        s = -1;
        for (int i = 0; i < 40 && s < 0; i++) begin
            tick();
            if (col == 4'b1110 && prev != 4'b1110) s = cyc;
            prev = col;
        end
        chk("bounce_sync", 32'(s >= 0), 32'd1);
        ovr = 4'b1110;
        ovr_en = 1'b1;
        tick();
        tick();
        tick();
        ovr_en = 1'b0;
        tick();
        tick();
        chk("bounce_frozen", col, 4'b1110);
        tick();
        chk("bounce_next", col, 4'b1101);
        repeat (30) tick();
        chk("bounce_pulses", pv_cyc.size(), 0);
        chk("bounce_num", num, model_num);

        // Rows 0 and 2 in column 2: row 0 wins; then reset while held
        press((16'h1 << 2) | (16'h1 << 10), 2, -1, 4'h3);
        chk("prio_code", key_code, 4'h3);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_col", col, 4'b1110);
        chk("mid_rst_num", num, 16'h0000);
        chk("mid_rst_code", key_code, 4'h0);
        chk("mid_rst_vld", key_valid, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        model_num = 0;
        press((16'h1 << 2) | (16'h1 << 10), 2, 20, 4'h3);
        chk("num_after_rst", num, 16'h0003);

        // Long hold of key 7
        press(16'h1 << 8, 0, 130, 4'h7);
`ifdef KEYPAD_AUTOREPEAT_EN
        chk("num_7777", num, 16'h7777);
`else
        chk("num_37", num, 16'h0037);
`endif

        // Randomized presses
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 12)) tick();
            kr = $urandom_range(0, 3);
            kc = $urandom_range(0, 3);
            press(16'h1 << (kr*4+kc), kc, $urandom_range(10, 100), code_of(kr, kc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
